ex_muldiv_ctrl: RTL and testbench
=================================

# ex_muldiv_ctrl

Sequencer for multi-cycle arithmetic in the EX stage. It accepts a multiply or divide request from the EX stage and runs an iterative 32-step shift-add multiply or restoring divide. While it runs, it holds the pipeline with a stall. When it finishes, it presents the result with a one-cycle `done` pulse so the EX stage can forward it into EXMEM as the ALU result. It sits beside the single-cycle ALU, gates the pipeline-hold logic with `stall`, and drives the `ALU_done` path for multi-cycle opcodes.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width.
- `ITER`, `WIDTH`, iterations per operation.

Ports (clock and reset first):
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  EX holds a valid mul/div instruction; level-sensitive.
- `op`  in  2  operation: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
- `operand_a`  in  WIDTH  multiplicand or dividend, after forwarding.
- `operand_b`  in  WIDTH  multiplier or divisor, after forwarding.
- `flush`  in  1  squash the EX instruction (branch/ret redirect).
- `stall`  out  1  hold PC, IFID and IDEX.
- `busy`  out  1  sequencer not IDLE.
- `done`  out  1  one-cycle pulse; `result` and flags valid.
- `result`  out  WIDTH  selected result word.
- `N_out`, `Z_out`, `V_out`  out  1 each  flags from `result`; V is always 0.
- `div_zero`  out  1  valid with `done`; divisor was 0.

## Operation
State machine:
- **IDLE → RUN**: on `start && !flush`. Latch `op`, `operand_a` and `operand_b`. Clear accumulator, remainder and count.
- **IDLE → DONE**: on `start && !flush`, when `op[1]` is set (divide) and `operand_b == 0`. No iterations are run.
- **RUN**: each cycle performs one iteration and increments the count.
  - MUL/MULHU: if the multiplier LSB is 1, add the multiplicand to the upper half of the 2·WIDTH product register. Then shift the product register right 1.
  - DIVU/REMU: shift {rem, quo} left 1. Trial-subtract the divisor from rem. If there is no borrow, keep the difference and set the quotient LSB.
  - Arithmetic is unsigned. The adder is WIDTH+1 bits; the carry/borrow is bit WIDTH.
- **RUN → DONE**: when count == ITER-1.
- **DONE → IDLE**: unconditional. A `start` seen in DONE is ignored; the next instruction reaches EX one cycle later.

Results:
- MUL returns product[WIDTH-1:0]; MULHU returns product[2W-1:W].
- DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: quotient = all ones, remainder = `operand_a`, `div_zero` = 1.

Other rules:
- `flush` in RUN or DONE returns to IDLE next cycle with no `done` pulse. `flush` has priority over every other transition.
- `rst` in any state returns to IDLE next cycle. All internal registers clear.
- Input changes during RUN are ignored because the operands were latched.

## Timing
- Reset values: `stall` 0, `busy` 0, `done` 0, `result` 0, `N_out` 0, `Z_out` 0, `V_out` 0, `div_zero` 0. State is IDLE, count is 0.
- `stall` is combinational: (IDLE && `start` && !`flush`) || RUN. It is therefore high in the same cycle the request appears, and low in DONE so the instruction advances.
- Latency: `start` at cycle 0 → `done` at cycle ITER+1 (33 for the defaults). The stall covers cycles 0..ITER.
- Divide by zero: `start` at cycle 0 → `done` at cycle 1. Stall is high in cycle 0 only.
- `result`, the flags and `div_zero` are registered and held until the next `done`. They are guaranteed only while `done` is high.
- `busy` = state != IDLE (registered).

## Structure
- Shared package `muldiv_pkg`:
  - op encodings `MD_MUL`, `MD_MULHU`, `MD_DIVU`, `MD_REMU`;
  - state enum `MD_IDLE`, `MD_RUN`, `MD_DONE`;
  - `MD_ITER_W` = clog2(ITER).
- One sub-module, `muldiv_datapath`: the product/remainder/quotient registers and the shared WIDTH+1 adder/subtractor. It has `load`, `step`, `is_div` controls.
- `ex_muldiv_ctrl` keeps the FSM, the counter, the stall/done logic, result selection and the flags.

## Test plan
- MUL 0x0000_1234 × 0x0000_0010, `start` held → `stall` high cycles 0–32; `done` at cycle 33; `result` 0x0001_2340; Z=0, N=0.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → `result` 0xFFFF_FFFE at `done`; N=1.
- DIVU 100 / 7, then REMU 100 / 7 issued back-to-back (second `start` raised in the DONE cycle) → `result` 14 at cycle 33; second `done` at cycle 67 with `result` 2.
- DIVU 0x1234 / 0 → `done` at cycle 1; `result` 0xFFFF_FFFF; `div_zero`=1; REMU 0x1234 / 0 returns 0x1234.
- MUL started, `flush` asserted at cycle 10 → IDLE at cycle 11; `stall`=0; no `done`; a new DIVU 9/3 then returns 3 at +33.
- `rst` asserted at cycle 5 of a DIVU → all outputs at reset values the next cycle; no `done` is ever seen for the aborted operation.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multi-cycle multiply/divide sequencer.
//   - op encodings (MD_MUL, MD_MULHU, MD_DIVU, MD_REMU)
//   - sequencer state enum (MD_IDLE, MD_RUN, MD_DONE)
//   - iteration-counter width helper and its default value
package muldiv_pkg;

    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Counter width able to hold 0..iter-1; never narrower than one bit.
    function automatic int md_iter_w(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

    localparam int MD_ITER_W = md_iter_w(32);

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiply / restoring divide datapath.
// One 2*WIDTH accumulator is shared by both operations:
//   multiply: acc = {product_hi, multiplier remaining}, opnd = multiplicand
//   divide:   acc = {remainder, quotient/dividend},     opnd = divisor
// A single WIDTH+1 adder adds (multiply) or subtracts (divide).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         capture operands and clear the upper accumulator half
//   step         perform one iteration
//   is_div       1 = divide iteration/load, 0 = multiply
//   load_a/b     operand_a / operand_b at load time
//   acc          current accumulator
//   acc_step     accumulator value after one more iteration (combinational)
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     load_a,
    input  logic [WIDTH-1:0]     load_b,
    output logic [2*WIDTH-1:0]   acc,
    output logic [2*WIDTH-1:0]   acc_step
);

    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opnd_reg;

    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic [WIDTH:0]     add_sum;

    assign acc_hi = acc_reg[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_reg[WIDTH-1:0];

    always_comb begin
        add_x    = '0;
        add_y    = '0;
        add_sum  = '0;
        acc_step = acc_reg;
        if (is_div) begin
            // Trial subtract of the divisor from the left-shifted remainder.
            add_x   = {acc_hi, acc_lo[WIDTH-1]};
            add_y   = {1'b0, opnd_reg};
            add_sum = add_x + ~add_y + {{WIDTH{1'b0}}, 1'b1};
            if (add_sum[WIDTH]) begin
                // Borrow: restore, i.e. keep the plain shift.
                acc_step = {acc_reg[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_step = {add_sum[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            add_x    = {1'b0, acc_hi};
            add_y    = acc_lo[0] ? {1'b0, opnd_reg} : '0;
            add_sum  = add_x + add_y;
            // Carry lands in the top bit as the product shifts right.
            acc_step = {add_sum, acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg  <= '0;
            opnd_reg <= '0;
        end else if (load) begin
            acc_reg  <= {{WIDTH{1'b0}}, (is_div ? load_a : load_b)};
            opnd_reg <= is_div ? load_b : load_a;
        end else if (step) begin
            acc_reg  <= acc_step;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage sequencer for multi-cycle MUL/MULHU/DIVU/REMU.
// Holds the pipeline with stall while iterating, then presents the result
// with a one-cycle done pulse.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, op              request and operation (00 MUL,01 MULHU,10 DIVU,11 REMU)
//   operand_a, operand_b   multiplicand/dividend, multiplier/divisor
//   flush                  squash the EX instruction
//   stall                  hold PC/IFID/IDEX (combinational)
//   busy                   sequencer not idle (registered)
//   done                   one-cycle result-valid pulse
//   result, N/Z/V_out      result word and flags (V always 0)
//   div_zero               divisor was zero (valid with done)
module ex_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             N_out,
    output logic             Z_out,
    output logic             V_out,
    output logic             div_zero
);

    localparam int CNT_W = md_iter_w(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    md_state_t          state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [1:0]         op_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               n_reg;
    logic               z_reg;
    logic               div_zero_reg;

    logic               accept;
    logic               dz_now;
    logic               dp_is_div;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   final_word;

    assign accept    = (state_reg == MD_IDLE) && start && !flush;
    assign dz_now    = op[1] && (operand_b == '0);
    // During load the incoming op decides the layout; afterwards the latched op.
    assign dp_is_div = (state_reg == MD_IDLE) ? op[1] : op_reg[1];

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     ((state_reg == MD_RUN) && !flush),
        .is_div   (dp_is_div),
        .load_a   (operand_a),
        .load_b   (operand_b),
        .acc      (acc),
        .acc_step (acc_step)
    );

    // Word captured on entry to DONE: either the divide-by-zero shortcut or
    // the accumulator after its final iteration. Upper half holds MULHU/REMU.
    always_comb begin
        final_word = '0;
        if (state_reg == MD_IDLE) begin
            final_word = op[0] ? operand_a : '1;
        end else begin
            final_word = op_reg[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= MD_IDLE;
            count_reg    <= '0;
            op_reg       <= MD_MUL;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
            n_reg        <= 1'b0;
            z_reg        <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (flush) begin
                state_reg <= MD_IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    MD_IDLE: begin
                        if (start) begin
                            op_reg    <= op;
                            count_reg <= '0;
                            busy_reg  <= 1'b1;
                            if (dz_now) begin
                                state_reg    <= MD_DONE;
                                done_reg     <= 1'b1;
                                result_reg   <= final_word;
                                n_reg        <= final_word[WIDTH-1];
                                z_reg        <= (final_word == '0);
                                div_zero_reg <= 1'b1;
                            end else begin
                                state_reg <= MD_RUN;
                            end
                        end
                    end
                    MD_RUN: begin
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == CNT_LAST) begin
                            state_reg    <= MD_DONE;
                            done_reg     <= 1'b1;
                            result_reg   <= final_word;
                            n_reg        <= final_word[WIDTH-1];
                            z_reg        <= (final_word == '0);
                            div_zero_reg <= 1'b0;
                        end
                    end
                    MD_DONE: begin
                        // A start seen here belongs to the next instruction,
                        // which only reaches EX one cycle later.
                        state_reg <= MD_IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= MD_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stall    = accept || (state_reg == MD_RUN);
    assign busy     = busy_reg;
    // A flush arriving in the DONE cycle squashes the pulse too.
    assign done     = done_reg && !flush;
    assign result   = result_reg;
    assign N_out    = n_reg;
    assign Z_out    = z_reg;
    assign V_out    = 1'b0;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        N_out;
    logic        Z_out;
    logic        V_out;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    ex_muldiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .N_out     (N_out),
        .Z_out     (Z_out),
        .V_out     (V_out),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a request in the current cycle (cycle 0) and let stall settle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        #1;
    endtask

    // Advance until done; lat = cycle of done (-1 on timeout). stall_ok is
    // 1 when stall was high in every cycle before done. With scramble set,
    // operands are changed after cycle 1 to show they are latched.
    task automatic wait_done(input int budget, input bit scramble,
                             output int lat, output bit stall_ok);
        stall_ok = stall;
        lat = 0;
        forever begin
            tick();
            lat++;
            if (done) break;
            stall_ok &= stall;
            if (scramble && lat == 1) begin
                operand_a = 32'hDEAD_BEEF;
                operand_b = 32'h0BAD_F00D;
                #1;
            end
            if (lat > budget) begin
                lat = -1;
                break;
            end
        end
    endtask

    // Count done pulses over n cycles.
    task automatic count_done(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) seen++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if ({N_out, Z_out, V_out} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {N_out, Z_out, V_out}); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
        $display("reset: stall=%b busy=%b done=%b result=%h", stall, busy, done, result);
    endtask

    task automatic test_mul();
        int lat; bit sok;
        issue(2'b00, 32'h0000_1234, 32'h0000_0010);
        wait_done(40, 1'b1, lat, sok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        checks++; if (sok !== 1'b1) begin errors++; $display("FAIL mul_stall_cover got=%b exp=1", sok); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_stall_at_done got=%b exp=0", stall); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_at_done got=%b exp=1", busy); end
        checks++; if (result !== 32'h0001_2340) begin errors++; $display("FAIL mul_result got=%h exp=00012340", result); end
        checks++; if ({N_out, Z_out, V_out, div_zero} !== 4'b0000) begin errors++; $display("FAIL mul_flags got=%b exp=0000", {N_out, Z_out, V_out, div_zero}); end
        $display("MUL 00001234*00000010: lat=%0d result=%h N=%b Z=%b", lat, result, N_out, Z_out);
        start = 1'b0;
        tick();
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL mul_after_done got=%b exp=00", {done, busy}); end
    endtask

    task automatic test_mulhu();
        int lat; bit sok;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(40, 1'b0, lat, sok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mulhu_latency got=%0d exp=33", lat); end
        checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result got=%h exp=fffffffe", result); end
        checks++; if ({N_out, Z_out} !== 2'b10) begin errors++; $display("FAIL mulhu_flags got=%b exp=10", {N_out, Z_out}); end
        $display("MULHU ffffffff*ffffffff: lat=%0d result=%h N=%b", lat, result, N_out);
        start = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat; int lat2; bit sok;
        issue(2'b10, 32'd100, 32'd7);
        wait_done(40, 1'b0, lat, sok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_divu_latency got=%0d exp=33", lat); end
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL b2b_divu_result got=%0d exp=14", result); end
        $display("DIVU 100/7: lat=%0d result=%0d", lat, result);
        // Next instruction presented during the DONE cycle: must be ignored there.
        op = 2'b11;
        tick();
        checks++; if ({done, busy, stall} !== 3'b001) begin errors++; $display("FAIL b2b_idle_cycle got=%b exp=001", {done, busy, stall}); end
        wait_done(40, 1'b0, lat2, sok);
        checks++; if (lat + 1 + lat2 !== 67) begin errors++; $display("FAIL b2b_remu_latency got=%0d exp=67", lat + 1 + lat2); end
        checks++; if (result !== 32'd2) begin errors++; $display("FAIL b2b_remu_result got=%0d exp=2", result); end
        $display("REMU 100/7: done_cycle=%0d result=%0d", lat + 1 + lat2, result);
        start = 1'b0;
        tick();
    endtask

    task automatic test_div_zero();
        int lat; bit sok;
        issue(2'b10, 32'h0000_1234, 32'h0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL dz_stall_c0 got=%b exp=1", stall); end
        wait_done(5, 1'b0, lat, sok);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dz_stall_c1 got=%b exp=0", stall); end
        checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_divu_result got=%h exp=ffffffff", result); end
        checks++; if ({div_zero, N_out} !== 2'b11) begin errors++; $display("FAIL dz_divu_flags got=%b exp=11", {div_zero, N_out}); end
        $display("DIVU 1234/0: lat=%0d result=%h div_zero=%b", lat, result, div_zero);
        start = 1'b0;
        tick();
        issue(2'b11, 32'h0000_1234, 32'h0);
        wait_done(5, 1'b0, lat, sok);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_remu_latency got=%0d exp=1", lat); end
        checks++; if (result !== 32'h0000_1234) begin errors++; $display("FAIL dz_remu_result got=%h exp=00001234", result); end
        checks++; if ({div_zero, N_out, Z_out} !== 3'b100) begin errors++; $display("FAIL dz_remu_flags got=%b exp=100", {div_zero, N_out, Z_out}); end
        $display("REMU 1234/0: lat=%0d result=%h div_zero=%b", lat, result, div_zero);
        start = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        int lat; int seen; bit sok;
        issue(2'b00, 32'h0000_0003, 32'h0000_0005);
        for (int c = 1; c <= 10; c++) tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall_c10 got=%b exp=1", stall); end
        flush = 1'b1;
        start = 1'b0;
        tick();
        flush = 1'b0;
        #1;
        checks++; if ({busy, stall, done} !== 3'b000) begin errors++; $display("FAIL flush_idle_c11 got=%b exp=000", {busy, stall, done}); end
        count_done(40, seen);
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        $display("MUL flushed at cycle 10: done pulses=%0d", seen);
        issue(2'b10, 32'd9, 32'd3);
        wait_done(40, 1'b0, lat, sok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL flush_divu_latency got=%0d exp=33", lat); end
        checks++; if (result !== 32'd3) begin errors++; $display("FAIL flush_divu_result got=%0d exp=3", result); end
        $display("DIVU 9/3 after flush: lat=%0d result=%0d", lat, result);
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        int seen;
        issue(2'b10, 32'd1000, 32'd10);
        for (int c = 1; c <= 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        #1;
        checks++; if ({stall, busy, done, N_out, Z_out, V_out, div_zero} !== 7'b0) begin errors++; $display("FAIL rst_abort_ctrl got=%b exp=0000000", {stall, busy, done, N_out, Z_out, V_out, div_zero}); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_abort_result got=%h exp=0", result); end
        count_done(40, seen);
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_abort_no_done got=%0d exp=0", seen); end
        $display("DIVU reset at cycle 5: result=%h done pulses=%0d", result, seen);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulhu();
        test_back_to_back();
        test_div_zero();
        test_flush();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
